// File: rtl/pixel_write_arbiter.sv
// Selects one screen subsystem's pixel writes, maps (x,y) to a linear address and
// queues them for the frame buffer. Optional macro: PIXEL_TRANSPARENCY_EN (colour-key drop).
module pixel_write_arbiter #(
    parameter int         SCREEN_W    = 320,
    parameter int         SCREEN_H    = 240,
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] TRANSPARENT = 8'hE3,
    parameter int         ADDR_W      = 17
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [1:0]        SRC_SEL,
    input  logic [2:0]        SRC_WE,
    input  logic [23:0]       SRC_DOUT,
    input  logic [26:0]       SRC_X,
    input  logic [26:0]       SRC_Y,
    output logic [2:0]        STALL,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [7:0]        FB_DATA,
    input  logic              FB_READY,
    output logic              IDLE,
    output logic [15:0]       DROP_COUNT,
    input  logic              CLEAR_DROPS
);

    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] LP_W  = SCREEN_W;
    localparam logic [31:0] LP_H  = SCREEN_H;

    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W+7:0]   r_mem [FIFO_DEPTH];

    logic                r_s1_valid;
    logic [8:0]          r_s1_x;
    logic [8:0]          r_s1_y;
    logic [7:0]          r_s1_col;
    logic [15:0]         r_drops;

    logic                w_thresh;
    logic                w_sel_we;
    logic [8:0]          w_sel_x;
    logic [8:0]          w_sel_y;
    logic [7:0]          w_sel_col;
    logic                w_accept;
    logic                w_oor;
    logic                w_key;
    logic                w_drop;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W+7:0]   w_head;

    // One slot stays free for the entry that may already sit in stage 1.
    assign w_thresh = (r_count >= CNT_W'(FIFO_DEPTH - 1));

    always_comb begin
        STALL     = '1;
        w_sel_we  = 1'b0;
        w_sel_x   = '0;
        w_sel_y   = '0;
        w_sel_col = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (SRC_SEL == 2'(i)) begin
                STALL[i]  = w_thresh;
                w_sel_we  = SRC_WE[i];
                w_sel_x   = SRC_X[9*i +: 9];
                w_sel_y   = SRC_Y[9*i +: 9];
                w_sel_col = SRC_DOUT[8*i +: 8];
            end
        end
    end

    assign w_accept = w_sel_we & ~w_thresh;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_col   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_x   <= w_sel_x;
                r_s1_y   <= w_sel_y;
                r_s1_col <= w_sel_col;
            end
        end
    end

    assign w_oor  = (32'(r_s1_x) >= LP_W) | (32'(r_s1_y) >= LP_H);
    assign w_addr = ADDR_W'(r_s1_y) * ADDR_W'(SCREEN_W) + ADDR_W'(r_s1_x);

`ifdef PIXEL_TRANSPARENCY_EN
    assign w_key = (r_s1_col == TRANSPARENT);
`else
    logic w_unused_key;
    assign w_unused_key = ^TRANSPARENT;
    assign w_key        = 1'b0;
`endif

    assign w_drop  = r_s1_valid & (w_oor | w_key);
    assign w_push  = r_s1_valid & ~w_oor & ~w_key;
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & FB_READY;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_addr, r_s1_col};
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_drops <= '0;
        end else if (CLEAR_DROPS) begin
            r_drops <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && r_drops != 16'hFFFF) begin
            r_drops <= r_drops + 16'd1;
        end
    end

    // Outputs read zero while empty so stale memory never appears on the port.
    assign w_head     = r_mem[r_rd_ptr];
    assign FB_WE      = ~w_empty;
    assign FB_ADDR    = w_empty ? '0 : w_head[ADDR_W+7:8];
    assign FB_DATA    = w_empty ? '0 : w_head[7:0];
    assign IDLE       = w_empty & ~r_s1_valid;
    assign DROP_COUNT = r_drops;

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Downstream of the screen subsystems (game engine, you-win, game-over). Selects one subsystem's pixel write stream and converts each (x, y, colour) write into a linear frame-buffer address. Buffers the writes in a FIFO and drains them to the frame-buffer memory port under a ready/valid handshake. The system FSM uses `IDLE` to know that a screen's writes have fully landed before it starts the next screen.

## Interface
Parameters:
- `SCREEN_W`, 320: visible width in pixels.
- `SCREEN_H`, 240: visible height in pixels.
- `FIFO_DEPTH`, 16: write FIFO entries; must be a power of 2, ≥ 4.
- `TRANSPARENT`, 8'hE3: colour key, used only when transparency is compiled in.
- `ADDR_W`, 17: frame-buffer address width.

Ports:
- `CLOCK_50` in 1: master clock. All logic is on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `SRC_SEL` in 2: source select from the system FSM. 0 = engine, 1 = you-win, 2 = game-over, 3 = none.
- `SRC_WE` in 3: per-source write strobe. Bit i belongs to source i.
- `SRC_DOUT` in 24: per-source pixel colour, 8 bits each. Source i is `[8i+7:8i]`.
- `SRC_X` in 27: per-source x coordinate, 9 bits each.
- `SRC_Y` in 27: per-source y coordinate, 9 bits each.
- `STALL` out 3: per-source back-pressure. A source must hold its write while its bit is 1.
- `FB_WE` out 1: frame-buffer write valid.
- `FB_ADDR` out `ADDR_W`: linear address.
- `FB_DATA` out 8: pixel colour.
- `FB_READY` in 1: frame buffer accepts the write on the current edge.
- `IDLE` out 1: no write is pending anywhere in the block.
- `DROP_COUNT` out 16: saturating count of dropped pixels.
- `CLEAR_DROPS` in 1: synchronous clear of `DROP_COUNT`.

## Operation
- **Accept.** A write from source s is accepted on an edge when `SRC_SEL==s`, `SRC_WE[s]=1` and `STALL[s]=0`.
  - Writes from unselected sources are ignored and are not counted.
  - `SRC_SEL=3` ignores all sources.
- **Stage 1 (register).** Latches x, y and colour, and sets a stage-valid flag.
- **Range check.** Checked in stage 1. If `x>=SCREEN_W` or `y>=SCREEN_H`, the pixel is dropped: it is not written to the FIFO and `DROP_COUNT` increments.
- **Address.** `FB_ADDR = y*SCREEN_W + x`, computed in stage 1 and truncated to `ADDR_W` bits. The maximum, 76799, fits in 17 bits.
- **FIFO.** An in-range stage-1 entry is written into the FIFO at the end of stage 1. The FIFO is show-ahead: the head entry drives `FB_ADDR`/`FB_DATA`, and `FB_WE = !empty`.
- **Drain.** The head pops on an edge where `FB_WE & FB_READY`. While `FB_READY=0`, `FB_ADDR`/`FB_DATA` hold stable.
- **Back-pressure.**
  - `STALL[s] = (SRC_SEL!=s) | (count >= FIFO_DEPTH-1)`, where `count` is the registered FIFO occupancy. The threshold reserves one slot for the stage-1 entry.
  - The FIFO therefore never overflows, and a pop and a push in the same cycle both succeed.
- **`IDLE`.** `IDLE = fifo_empty & !stage_valid`.
- **`DROP_COUNT`.**
  - Saturates at 16'hFFFF.
  - `CLEAR_DROPS` on its own sets the count to 0.
  - A drop in the same cycle as `CLEAR_DROPS` sets the count to 1.
- **Select changes.** A `SRC_SEL` change mid-stream takes effect on the next accept. Entries already in stage 1 or in the FIFO still drain in order.
- **Reset.** Asserting `RESET_N` low at any time clears the FIFO and stage 1 and abandons any pending write; there is no partial write to the frame buffer.

## Timing
- **Reset values:**
  - `FB_WE=0`, `FB_ADDR=0`, `FB_DATA=0`.
  - `STALL` = 3'b111 until `SRC_SEL` is valid. Because `STALL` is combinational from `SRC_SEL`, it is 3'b111 while `SRC_SEL=3`; otherwise only the selected bit is 0.
  - `IDLE=1`, `DROP_COUNT=0`.
- **Latency.** A write accepted at edge N is in stage 1 after N. It is in the FIFO after N+1, and `FB_WE=1` with its address during cycle N+1→N+2. Minimum accept-to-`FB_WE` latency is 2 edges.
- **Throughput.** One pixel per cycle sustained when `FB_READY` is held high.
- **Ordering.** Writes reach the frame buffer in the order they were accepted; no reordering, no merging.
- **Handshake stability.** Once `FB_WE` is asserted, `FB_ADDR`/`FB_DATA` must not change until the transfer edge.

## Configuration
- `PIXEL_TRANSPARENCY_EN` defined: a stage-1 pixel whose colour equals `TRANSPARENT` is dropped like an out-of-range pixel, and it increments `DROP_COUNT`.
- `PIXEL_TRANSPARENCY_EN` undefined: every colour is written, including `TRANSPARENT`; the `TRANSPARENT` parameter is unused.

## Test plan
- **Single write.** Reset, then `SRC_SEL=1`, one write x=10, y=2, colour=8'h1C, with `FB_READY=1`. Required: `FB_WE` for exactly one cycle 2 edges later, `FB_ADDR=650`, `FB_DATA=8'h1C`, and `IDLE` returns to 1.
- **Back-pressure.** `FB_READY=0`, 20 back-to-back writes from source 0. Required: `STALL[0]` rises when count reaches 15 and no write is lost. Then set `FB_READY=1`: exactly 16 entries drain in order, then the remaining stalled writes follow.
- **Range drops.** Writes at (320,0), (0,240) and (319,239). Required: `DROP_COUNT=2`, and a single frame-buffer write at address 76799.
- **Select gating.** `SRC_SEL=0` while sources 1 and 2 strobe `SRC_WE`. Required: no `FB_WE`, `STALL=3'b110`, `DROP_COUNT` unchanged.
- **Reset mid-drain.** `RESET_N` pulsed low with 8 entries queued and `FB_READY=0`. Required: `FB_WE=0` immediately (asynchronously), `IDLE=1` after release, no stale writes afterwards.
- **Transparency.** Write colour 8'hE3. Required: dropped and counted with `PIXEL_TRANSPARENCY_EN` defined; written to the frame buffer without it.
